// File: rtl/arb_pkg.sv
// Shared types and defaults for the round-robin decoder arbiter.
// Holds the FSM state encoding and default width / hold limits.
package arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int ARB_N        = 2;
  localparam int ARB_MAX_HOLD = 4;

endpackage

// File: rtl/decoder_NxM.sv
// Binary-to-one-hot decoder, N index bits to 2^N outputs.
// Ports: in_i index, out_o one-hot (bit in_i set).
module decoder_NxM #(
  parameter int N = 2
) (
  input  logic [N-1:0]        in_i,
  output logic [(1<<N)-1:0]   out_o
);

  always_comb begin
    out_o       = '0;
    out_o[in_i] = 1'b1;
  end

endmodule

// File: rtl/rr_decoder_arbiter.sv
// Round-robin arbiter with hold-time preemption and one-hot grant.
// Ports: clk, rst (sync high), req[M], gnt[M], gnt_idx[N], gnt_valid.
module rr_decoder_arbiter
  import arb_pkg::*;
#(
  parameter int N        = ARB_N,
  parameter int M        = 1 << N,
  parameter int MAX_HOLD = ARB_MAX_HOLD
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [M-1:0] req,
  output logic [M-1:0] gnt,
  output logic [N-1:0] gnt_idx,
  output logic         gnt_valid
);

  localparam int HW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  // Saturation value of the hold counter; stays 0 when preemption is off.
  localparam logic [HW-1:0] HOLD_TOP =
    (MAX_HOLD > 0) ? HW'(MAX_HOLD - 1) : '0;

  arb_state_e  state_q, state_d;
  logic [N-1:0]  ptr_q, ptr_d;
  logic [N-1:0]  idx_q, idx_d;
  logic [HW-1:0] hold_q, hold_d;

  logic [M-1:0] cur_oh;
  logic [M-1:0] others;
  logic [M-1:0] srch;
  logic [N-1:0] pick;
  logic         pick_ok;
  logic         timeout;
  logic         take;

  decoder_NxM #(
    .N (N)
  ) u_dec (
    .in_i  (idx_q),
    .out_o (cur_oh)
  );

  assign gnt_valid = (state_q == BUSY);
  assign gnt_idx   = idx_q;
  assign gnt       = cur_oh & {M{gnt_valid}};

  assign others  = req & ~cur_oh;
  // While busy the current holder is never a candidate for a new grant.
  assign srch    = (state_q == BUSY) ? others : req;
  assign timeout = (MAX_HOLD > 0) && (hold_q == HOLD_TOP);

  // Circular search from ptr; walk backwards so the nearest hit wins.
  always_comb begin
    logic [N-1:0] cand;
    pick    = '0;
    pick_ok = 1'b0;
    cand    = '0;
    for (int i = M - 1; i >= 0; i--) begin
      cand = ptr_q + N'(i);
      if (srch[cand]) begin
        pick    = cand;
        pick_ok = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    take    = 1'b0;
    unique case (state_q)
      IDLE: begin
        take = pick_ok;
      end
      BUSY: begin
        if (!req[idx_q] || timeout) begin
          if (pick_ok) begin
            take = 1'b1;
          end else if (!req[idx_q]) begin
            state_d = IDLE;
            hold_d  = '0;
          end
        end else if (hold_q != HOLD_TOP) begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (take) begin
      state_d = BUSY;
      idx_d   = pick;
      ptr_d   = pick + N'(1);
      hold_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
    end
  end

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// Self-checking bench for rr_decoder_arbiter (N=2, MAX_HOLD=4).
// Behavioural model checked every cycle plus literal expectations.
module tb_rr_decoder_arbiter;

  localparam int N  = 2;
  localparam int M  = 4;
  localparam int MH = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [M-1:0] req = '0;
  logic [M-1:0] gnt;
  logic [N-1:0] gnt_idx;
  logic         gnt_valid;

  int n_vec = 0;
  int n_bad = 0;
  bit armed = 1'b0;

  int m_valid = 0;
  int m_idx   = 0;
  int m_ptr   = 0;
  int m_hold  = 0;

  rr_decoder_arbiter #(
    .N        (N),
    .MAX_HOLD (MH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  always #5 clk = ~clk;

  function automatic int first_from(input logic [M-1:0] v, input int p);
    for (int i = 0; i < M; i++)
      if (v[(p + i) % M]) return (p + i) % M;
    return -1;
  endfunction

  function automatic void grant(input int k);
    m_valid = 1;
    m_idx   = k;
    m_ptr   = (k + 1) % M;
    m_hold  = 0;
  endfunction

  always @(posedge clk) begin
    logic [M-1:0] oth;
    int k;
    if (rst) begin
      m_valid = 0; m_idx = 0; m_ptr = 0; m_hold = 0;
    end else if (m_valid == 0) begin
      k = first_from(req, m_ptr);
      if (k >= 0) grant(k);
    end else begin
      oth = req;
      oth[m_idx] = 1'b0;
      k = first_from(oth, m_ptr);
      if (!req[m_idx]) begin
        if (k >= 0) grant(k);
        else begin m_valid = 0; m_hold = 0; end
      end else if (MH > 0 && m_hold == MH - 1 && k >= 0) begin
        grant(k);
      end else if (m_hold < MH - 1) begin
        m_hold = m_hold + 1;
      end
    end
    armed <= 1'b1;
  end

  always @(negedge clk) begin
    logic [M-1:0] eg;
    if (armed) begin
      eg = '0;
      if (m_valid != 0) eg[m_idx] = 1'b1;
      n_vec++;
      if (gnt !== eg || gnt_valid !== (m_valid != 0) ||
          gnt_idx !== N'(m_idx)) begin
        n_bad++;
        $display("FAIL model t=%0t: gnt=%b valid=%b idx=%0d want gnt=%b valid=%0d idx=%0d",
                 $time, gnt, gnt_valid, gnt_idx, eg, m_valid, m_idx);
      end
    end
  end

  task automatic step(input logic r, input logic [M-1:0] q);
    rst = r;
    req = q;
    @(posedge clk);
    #2;
  endtask

  task automatic lit(input string nm, input logic [M-1:0] eg,
                     input logic ev, input logic [N-1:0] ei);
    n_vec++;
    if (gnt !== eg || gnt_valid !== ev || gnt_idx !== ei) begin
      n_bad++;
      $display("FAIL %s: gnt=%b valid=%b idx=%0d want gnt=%b valid=%b idx=%0d",
               nm, gnt, gnt_valid, gnt_idx, eg, ev, ei);
    end
  endtask

  logic [M-1:0] tbl [0:16] = '{
    4'b0110, 4'b0110, 4'b0100, 4'b1101, 4'b1101, 4'b1101,
    4'b1101, 4'b1101, 4'b1001, 4'b0000, 4'b1111, 4'b1111,
    4'b1111, 4'b1111, 4'b1111, 4'b0111, 4'b0000
  };

  initial begin
    step(1, 4'b1111); lit("rst1", 4'b0000, 0, 0);
    step(1, 4'b1111); lit("rst2", 4'b0000, 0, 0);
    step(0, 4'b1111); lit("after_rst", 4'b0001, 1, 0);
    step(0, 4'b0000); lit("release0", 4'b0000, 0, 0);

    step(1, 4'b0000);
    step(0, 4'b0100); lit("single", 4'b0100, 1, 2);
    step(0, 4'b0000); lit("single_rel", 4'b0000, 0, 2);

    step(1, 4'b0000);
    step(0, 4'b1010); lit("b2b_first", 4'b0010, 1, 1);
    step(0, 4'b1000); lit("b2b_hand", 4'b1000, 1, 3);
    step(0, 4'b0000); lit("b2b_rel", 4'b0000, 0, 3);
    step(0, 4'b0101); lit("wrap", 4'b0001, 1, 0);
    step(0, 4'b0100); lit("wrap_next", 4'b0100, 1, 2);
    step(0, 4'b0000); lit("wrap_rel", 4'b0000, 0, 2);

    step(1, 4'b0000);
    for (int i = 0; i < 9; i++) begin
      step(0, 4'b0011);
      if (i < 4)      lit("preempt_a", 4'b0001, 1, 0);
      else if (i < 8) lit("preempt_b", 4'b0010, 1, 1);
      else            lit("preempt_c", 4'b0001, 1, 0);
    end
    for (int i = 0; i < 8; i++) begin
      step(0, 4'b0001); lit("persist", 4'b0001, 1, 0);
    end

    step(1, 4'b0000);
    step(0, 4'b1000); lit("mid_gnt", 4'b1000, 1, 3);
    step(1, 4'b1001); lit("mid_rst", 4'b0000, 0, 0);
    step(0, 4'b1001); lit("post_rst", 4'b0001, 1, 0);

    foreach (tbl[i]) step(0, tbl[i]);
    step(1, 4'b1111);
    step(0, 4'b0000);

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/rr_decoder_arbiter.md
RR_DECODER_ARBITER -- requirements
Module: rr_decoder_arbiter

Interface
REQ-001 Parameter N, default 2: requester index width in bits.
REQ-002 Parameter M, default (1 << N): number of requesters, always 2^N, derived and not overridden.
REQ-003 Parameter MAX_HOLD, default 4: maximum consecutive grant cycles while others wait; 0 disables preemption.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req  input  M  request vector; bit i is requester i; held high until that requester is done.
REQ-007 gnt  output  M  one-hot grant; all zeros when gnt_valid is 0.
REQ-008 gnt_idx  output  N  binary index of the current grantee; registered.
REQ-009 gnt_valid  output  1  high while a grant is active; registered.

Function
REQ-010 The block SHALL implement two states: IDLE (no grant) and BUSY (grant held by gnt_idx).
REQ-011 Internal pointer ptr (N bits) SHALL mark the highest-priority index; search order is ptr, ptr+1, ..., ptr-1 modulo M.
REQ-012 On every new grant to index k, ptr SHALL load (k+1) mod M, wrapping from M-1 to 0.
REQ-013 IDLE with req != 0 at an edge SHALL select the first set bit in search order, load gnt_idx, set gnt_valid and enter BUSY (1-cycle latency from req to gnt).
REQ-014 IDLE with req == 0 SHALL keep gnt_valid = 0 and gnt = 0.
REQ-015 BUSY with req[gnt_idx] = 1 and no preemption SHALL hold gnt_idx and gnt unchanged.
REQ-016 BUSY with req[gnt_idx] = 0 and another bit set SHALL grant the next requester in search order on the same edge, with no idle cycle between grants.
REQ-017 BUSY with req[gnt_idx] = 0 and req == 0 SHALL clear gnt_valid and return to IDLE; gnt_idx holds its last value.
REQ-018 hold_cnt SHALL clear on each new grant and increment each BUSY cycle, saturating at MAX_HOLD-1.
REQ-019 If MAX_HOLD > 0, hold_cnt == MAX_HOLD-1, and any other req bit is set, the next edge SHALL grant the next requester in search order even if req[gnt_idx] is still 1.
REQ-020 If no other request is pending at timeout, the current grant SHALL persist with hold_cnt saturated.
REQ-021 When release and timeout occur on the same edge, the block SHALL take the release action; the outcome is identical.
REQ-022 A requester that re-asserts immediately after release or preemption SHALL have lowest priority (due to the ptr update).
REQ-023 gnt SHALL equal the one-hot decode of gnt_idx gated by gnt_valid; exactly one bit is set while valid, none otherwise.

Reset
REQ-024 On rst = 1 at an edge: state = IDLE, ptr = 0, gnt_idx = 0, gnt_valid = 0, hold_cnt = 0, so gnt = 0 from the next cycle.
REQ-025 rst SHALL override all other inputs, including mid-grant; the first grant after reset follows REQ-013 with ptr = 0.

Structure
REQ-026 The state encodings (IDLE = 0, BUSY = 1) SHALL reside in shared package arb_pkg, together with the default N and MAX_HOLD constants.
REQ-027 The gnt one-hot output SHALL come from one instance of the existing decoder_NxM (parameter N), with its output ANDed with gnt_valid.
REQ-028 The round-robin search, state register, ptr and hold_cnt SHALL remain in rr_decoder_arbiter; no further sub-modules.

Verification
REQ-029 Reset: rst = 1 for 2 cycles with req = 1111 -> gnt = 0000, gnt_valid = 0, gnt_idx = 0; one cycle after rst drops -> gnt = 0001.
REQ-030 Single request: req = 0100 from IDLE (ptr = 0) -> next edge gnt = 0100, gnt_idx = 2, gnt_valid = 1; req = 0000 -> next edge gnt_valid = 0.
REQ-031 Back-to-back handoff: req = 1010 from IDLE (ptr = 0) -> gnt = 0010; req[1] drops, req[3] held -> next edge gnt = 1000 with no zero cycle.
REQ-032 Wrap-around: grant idx 3 released (ptr = 0), req = 0101 -> gnt = 0001; then drop req[0] -> gnt = 0100.
REQ-033 Preemption (MAX_HOLD = 4): req = 0011 held -> gnt = 0001 for exactly 4 cycles, then 0010 for 4, then 0001; with req = 0001 only -> gnt = 0001 persists indefinitely.
REQ-034 Reset mid-grant: gnt = 1000 active, rst pulsed for 1 cycle with req = 1001 -> gnt = 0000 for that cycle, then gnt = 0001 (ptr = 0).
